// File: rtl/tpu_pkg.sv
// Shared TPU job-controller definitions: FSM state encoding and bus address regions.
package tpu_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_A,
        LOAD_B,
        CLR_C,
        MM_START,
        MM_WAIT,
        READ_C,
        DONE
    } tpu_state_e;

    // Region selector placed in tpu_addr[11:8]
    localparam logic [3:0] REG_A  = 4'h1;
    localparam logic [3:0] REG_B  = 4'h2;
    localparam logic [3:0] REG_C  = 4'h3;
    localparam logic [3:0] REG_MM = 4'h4;

    function automatic logic [11:0] region_base(input logic [3:0] region);
        return {region, 8'h00};
    endfunction

endpackage

// File: rtl/tpu_job_ctrl.sv
// Sequences one TPU matmul job: stream A/B rows in, optionally clear C, kick the
// array, wait for it, then stream C back out.
module tpu_job_ctrl
    import tpu_pkg::*;
#(
    parameter int DIM     = 8,
    parameter int BITS_AB = 8,
    parameter int BITS_C  = 16,
    parameter int DATAW   = 64,
    parameter int ADDRW   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             accum,
    output logic             busy,
    output logic             done,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [DATAW-1:0] op_data,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [DATAW-1:0] res_data,
    output logic             tpu_r_w,
    output logic [ADDRW-1:0] tpu_addr,
    output logic [DATAW-1:0] tpu_din,
    input  logic [DATAW-1:0] tpu_dout
);

    localparam int IW       = $clog2(2*DIM);
    localparam int WW       = $clog2(4*DIM);
    // Bus words per A/B row and per C row (1 and 2 at the default geometry)
    localparam int AB_WORDS = (DIM*BITS_AB + DATAW - 1) / DATAW;
    localparam int C_WORDS  = (DIM*BITS_C + DATAW - 1) / DATAW;

    localparam logic [IW-1:0] LD_LAST   = IW'(DIM*AB_WORDS - 1);
    localparam logic [IW-1:0] C_LAST    = IW'(DIM*C_WORDS - 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(4*DIM - 1);

    tpu_state_e      state_q;
    logic [IW-1:0]   idx_q;
    logic [WW-1:0]   wait_q;
    logic            accum_q;
    logic [ADDRW-1:0] idx_off;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            wait_q  <= '0;
            accum_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    accum_q <= accum;
                    idx_q   <= '0;
                    state_q <= LOAD_A;
                end
                LOAD_A: if (op_valid) begin
                    if (idx_q == LD_LAST) begin
                        idx_q   <= '0;
                        state_q <= LOAD_B;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                LOAD_B: if (op_valid) begin
                    if (idx_q == LD_LAST) begin
                        idx_q   <= '0;
                        state_q <= accum_q ? MM_START : CLR_C;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                CLR_C: begin
                    if (idx_q == C_LAST) begin
                        idx_q   <= '0;
                        state_q <= MM_START;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                MM_START: begin
                    wait_q  <= '0;
                    state_q <= MM_WAIT;
                end
                MM_WAIT: begin
                    if (wait_q == WAIT_LAST) begin
                        wait_q  <= '0;
                        state_q <= READ_C;
                    end else begin
                        wait_q <= wait_q + 1'b1;
                    end
                end
                READ_C: if (res_ready) begin
                    if (idx_q == C_LAST) begin
                        idx_q   <= '0;
                        state_q <= DONE;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // idx<<3 yields row<<3 for A/B and (row<<4)|(half<<3) for C, half being idx[0]
    assign idx_off = ADDRW'(idx_q) << 3;

    always_comb begin
        busy      = (state_q != IDLE);
        done      = (state_q == DONE);
        op_ready  = (state_q == LOAD_A) || (state_q == LOAD_B);
        res_valid = (state_q == READ_C);
        tpu_r_w   = 1'b0;
        tpu_addr  = '0;
        tpu_din   = '0;
        res_data  = '0;
        case (state_q)
            LOAD_A: begin
                tpu_r_w  = op_valid;
                tpu_addr = ADDRW'(region_base(REG_A)) | idx_off;
                tpu_din  = op_data;
            end
            LOAD_B: begin
                tpu_r_w  = op_valid;
                tpu_addr = ADDRW'(region_base(REG_B)) | idx_off;
                tpu_din  = op_data;
            end
            CLR_C: begin
                tpu_r_w  = 1'b1;
                tpu_addr = ADDRW'(region_base(REG_C)) | idx_off;
            end
            MM_START: tpu_addr = ADDRW'(region_base(REG_MM));
            READ_C: begin
                tpu_addr = ADDRW'(region_base(REG_C)) | idx_off;
                res_data = tpu_dout;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_tpu_job_ctrl.sv
// Directed scoreboard bench for tpu_job_ctrl with a behavioural TPU memory/matmul model.
module tb_tpu_job_ctrl;

    localparam int DIM     = 8;
    localparam int BITS_AB = 8;
    localparam int BITS_C  = 16;
    localparam int DATAW   = 64;
    localparam int ADDRW   = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start, accum, busy, done;
    logic             op_valid, op_ready;
    logic [DATAW-1:0] op_data;
    logic             res_valid, res_ready;
    logic [DATAW-1:0] res_data;
    logic             tpu_r_w;
    logic [ADDRW-1:0] tpu_addr;
    logic [DATAW-1:0] tpu_din, tpu_dout;

    int n_checks = 0;
    int n_fail   = 0;

    tpu_job_ctrl #(
        .DIM(DIM), .BITS_AB(BITS_AB), .BITS_C(BITS_C), .DATAW(DATAW), .ADDRW(ADDRW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .accum(accum), .busy(busy), .done(done),
        .op_valid(op_valid), .op_ready(op_ready), .op_data(op_data),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .tpu_r_w(tpu_r_w), .tpu_addr(tpu_addr), .tpu_din(tpu_din), .tpu_dout(tpu_dout)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] lane_add(input logic [63:0] x, input logic [63:0] y);
        logic [63:0] r;
        for (int l = 0; l < 4; l++) r[l*16 +: 16] = x[l*16 +: 16] + y[l*16 +: 16];
        return r;
    endfunction

    // C word w covers row w/2, columns (w%2)*4 .. (w%2)*4+3
    function automatic logic [63:0] mm_word(input logic [63:0] a [DIM], input logic [63:0] b [DIM],
                                            input int w);
        logic [63:0] r;
        logic [15:0] s;
        int i, j;
        r = '0;
        i = w / 2;
        for (int e = 0; e < 4; e++) begin
            j = (w % 2) * 4 + e;
            s = '0;
            for (int k = 0; k < DIM; k++)
                s = s + 16'(a[i][k*8 +: 8]) * 16'(b[k][j*8 +: 8]);
            r[e*16 +: 16] = s;
        end
        return r;
    endfunction

    function automatic int job_lat(input logic acc);
        return 1 + DIM + DIM + (acc ? 0 : 2*DIM) + 1 + 4*DIM + 2*DIM;
    endfunction

    // Behavioural TPU: register file plus accumulate-on-kick matmul
    logic [63:0]      a_mem [DIM];
    logic [63:0]      b_mem [DIM];
    logic [63:0]      c_mem [2*DIM];
    logic [ADDRW-1:0] a_log [$];
    logic [ADDRW-1:0] b_log [$];
    int wr_total = 0, c_wr = 0, c_wr_at_mm = 0, mm_count = 0, bad_wr = 0, spurious_wr = 0;

    assign tpu_dout = (tpu_addr[11:8] == 4'h3) ? c_mem[tpu_addr[6:3]] : '0;

    always @(posedge clk) begin
        if (tpu_r_w) begin
            wr_total++;
            if (op_ready && !op_valid) spurious_wr++;
            case (tpu_addr[11:8])
                4'h1: begin a_mem[tpu_addr[5:3]] = tpu_din; a_log.push_back(tpu_addr); end
                4'h2: begin b_mem[tpu_addr[5:3]] = tpu_din; b_log.push_back(tpu_addr); end
                4'h3: begin c_mem[tpu_addr[6:3]] = tpu_din; c_wr++; end
                default: bad_wr++;
            endcase
        end else if (tpu_addr[11:8] == 4'h4) begin
            mm_count++;
            c_wr_at_mm = c_wr;
            for (int w = 0; w < 2*DIM; w++) c_mem[w] = lane_add(c_mem[w], mm_word(a_mem, b_mem, w));
        end
    end

    // Scoreboard state
    logic [63:0]      op_a [DIM];
    logic [63:0]      op_b [DIM];
    logic [63:0]      c_ref [2*DIM];
    logic [63:0]      exp_q [$];
    logic [63:0]      got_q [$];
    logic [ADDRW-1:0] stall_addr_q [$];
    logic [63:0]      stall_data_q [$];

    task automatic run_job(input logic acc, input bit gaps, input int stall_word, input int stall_len,
                           input bit poke_start, output int lat, output int dones);
        int k, sent, rcv, stall_left, extra;
        bit toggle, poked;
        for (int w = 0; w < 2*DIM; w++) begin
            c_ref[w] = acc ? lane_add(c_ref[w], mm_word(op_a, op_b, w)) : mm_word(op_a, op_b, w);
            exp_q.push_back(c_ref[w]);
        end
        lat = -1; dones = 0; k = 0; sent = 0; rcv = 0; extra = 0;
        stall_left = stall_len; toggle = 1'b0; poked = 1'b0;
        start = 1'b1; accum = acc;
        @(posedge clk); @(negedge clk);
        start = 1'b0; accum = 1'b0;
        while (k < 400 && extra < 4) begin
            start = 1'b0;
            if (poke_start && !poked && op_ready && sent == DIM + 2) begin
                start = 1'b1; accum = 1'b1; poked = 1'b1;
            end
            op_valid = 1'b0;
            if (op_ready && sent < 2*DIM) begin
                if (!gaps || toggle) begin
                    op_valid = 1'b1;
                    op_data  = (sent < DIM) ? op_a[sent] : op_b[sent - DIM];
                    sent++;
                end
                toggle = !toggle;
            end
            res_ready = 1'b1;
            if (res_valid) begin
                if (rcv == stall_word && stall_left > 0) begin
                    res_ready = 1'b0;
                    stall_left--;
                    stall_addr_q.push_back(tpu_addr);
                    stall_data_q.push_back(res_data);
                end else begin
                    got_q.push_back(res_data);
                    rcv++;
                end
            end
            if (done) begin
                dones++;
                if (lat < 0) lat = k + 1;
            end
            if (lat >= 0) extra++;
            @(posedge clk); k++; @(negedge clk);
        end
        start = 1'b0; accum = 1'b0; op_valid = 1'b0; res_ready = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; accum = 1'b0; op_valid = 1'b0; op_data = '0; res_ready = 1'b1;
        for (int w = 0; w < 2*DIM; w++) begin c_mem[w] = '0; c_ref[w] = '0; end
        repeat (2) @(negedge clk);
        n_checks++;
        if ({busy, done, op_ready, res_valid, tpu_r_w} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b expected 00000", {busy, done, op_ready, res_valid, tpu_r_w});
        end
        n_checks++;
        if (tpu_addr !== '0 || tpu_din !== '0 || res_data !== '0) begin
            n_fail++;
            $display("FAIL reset_bus: got addr=%h din=%h res=%h expected all zero", tpu_addr, tpu_din, res_data);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_busy: got %b expected 0", busy);
        end
    endtask

    task automatic test_identity;
        int lat, dones, c0, m0, n;
        for (int i = 0; i < DIM; i++) begin
            op_a[i] = 64'h1 << (i*8);
            op_b[i] = 64'h0101_0101_0101_0101;
        end
        c0 = c_wr; m0 = mm_count;
        run_job(1'b0, 1'b0, -1, 0, 1'b0, lat, dones);
        n_checks++;
        if (lat !== job_lat(1'b0)) begin
            n_fail++; $display("FAIL ident_latency: got %0d expected %0d", lat, job_lat(1'b0));
        end
        n_checks++;
        if (c_wr_at_mm - c0 !== 2*DIM || mm_count - m0 !== 1) begin
            n_fail++;
            $display("FAIL ident_clear: got %0d C clears, %0d kicks expected %0d, 1", c_wr_at_mm - c0, mm_count - m0, 2*DIM);
        end
        n_checks++;
        if (got_q.size() !== 2*DIM) begin
            n_fail++; $display("FAIL ident_count: got %0d words expected %0d", got_q.size(), 2*DIM);
        end
        n = 0;
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            logic [63:0] g, e;
            g = got_q.pop_front(); e = exp_q.pop_front();
            n_checks++;
            if (g !== e || g !== 64'h0001_0001_0001_0001) begin
                n_fail++; $display("FAIL ident_word%0d: got %h expected %h", n, g, e);
            end
            n++;
        end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_accum;
        int lat, dones, c0, m0, n;
        c0 = c_wr; m0 = mm_count;
        run_job(1'b1, 1'b0, -1, 0, 1'b0, lat, dones);
        n_checks++;
        if (lat !== job_lat(1'b1)) begin
            n_fail++; $display("FAIL accum_latency: got %0d expected %0d", lat, job_lat(1'b1));
        end
        n_checks++;
        if (c_wr - c0 !== 0 || mm_count - m0 !== 1) begin
            n_fail++;
            $display("FAIL accum_noclear: got %0d C writes, %0d kicks expected 0, 1", c_wr - c0, mm_count - m0);
        end
        n_checks++;
        if (got_q.size() !== 2*DIM) begin
            n_fail++; $display("FAIL accum_count: got %0d words expected %0d", got_q.size(), 2*DIM);
        end
        n = 0;
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            logic [63:0] g, e;
            g = got_q.pop_front(); e = exp_q.pop_front();
            n_checks++;
            if (g !== e || g !== 64'h0002_0002_0002_0002) begin
                n_fail++; $display("FAIL accum_word%0d: got %h expected %h", n, g, e);
            end
            n++;
        end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_valid_gaps;
        int lat, dones, a0, b0, s0, n;
        for (int i = 0; i < DIM; i++) begin
            op_a[i] = {$urandom, $urandom} & 64'h0F0F_0F0F_0F0F_0F0F;
            op_b[i] = {$urandom, $urandom} & 64'h0F0F_0F0F_0F0F_0F0F;
        end
        a0 = a_log.size(); b0 = b_log.size(); s0 = spurious_wr;
        run_job(1'b0, 1'b1, -1, 0, 1'b0, lat, dones);
        n_checks++;
        if (a_log.size() - a0 !== DIM || b_log.size() - b0 !== DIM) begin
            n_fail++;
            $display("FAIL gaps_rows: got %0d A, %0d B writes expected %0d each", a_log.size() - a0, b_log.size() - b0, DIM);
        end else begin
            for (int i = 0; i < DIM; i++) begin
                n_checks++;
                if (a_log[a0+i] !== ADDRW'(16'h0100 + 8*i) || b_log[b0+i] !== ADDRW'(16'h0200 + 8*i)) begin
                    n_fail++;
                    $display("FAIL gaps_addr%0d: got A=%h B=%h expected %h %h", i, a_log[a0+i], b_log[b0+i],
                             16'h0100 + 8*i, 16'h0200 + 8*i);
                end
            end
        end
        n_checks++;
        if (spurious_wr - s0 !== 0) begin
            n_fail++; $display("FAIL gaps_idle_write: got %0d writes without op_valid expected 0", spurious_wr - s0);
        end
        n_checks++;
        if (dones !== 1 || got_q.size() !== 2*DIM) begin
            n_fail++; $display("FAIL gaps_count: got %0d dones, %0d words expected 1, %0d", dones, got_q.size(), 2*DIM);
        end
        n = 0;
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            logic [63:0] g, e;
            g = got_q.pop_front(); e = exp_q.pop_front();
            n_checks++;
            if (g !== e) begin n_fail++; $display("FAIL gaps_word%0d: got %h expected %h", n, g, e); end
            n++;
        end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_res_stall;
        int lat, dones, n;
        logic [63:0] w3;
        for (int i = 0; i < DIM; i++) begin
            op_a[i] = {$urandom, $urandom} & 64'h0707_0707_0707_0707;
            op_b[i] = {$urandom, $urandom} & 64'h0707_0707_0707_0707;
        end
        stall_addr_q.delete(); stall_data_q.delete();
        run_job(1'b0, 1'b0, 3, 5, 1'b0, lat, dones);
        w3 = exp_q[3];
        n_checks++;
        if (stall_addr_q.size() !== 5) begin
            n_fail++; $display("FAIL stall_cycles: got %0d stalled cycles expected 5", stall_addr_q.size());
        end
        for (int i = 0; i < stall_addr_q.size(); i++) begin
            n_checks++;
            if (stall_addr_q[i] !== 16'h0318 || stall_data_q[i] !== w3) begin
                n_fail++;
                $display("FAIL stall_hold%0d: got addr=%h data=%h expected 0318 %h", i, stall_addr_q[i], stall_data_q[i], w3);
            end
        end
        n_checks++;
        if (got_q.size() !== 2*DIM) begin
            n_fail++; $display("FAIL stall_count: got %0d words expected %0d", got_q.size(), 2*DIM);
        end
        n = 0;
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            logic [63:0] g, e;
            g = got_q.pop_front(); e = exp_q.pop_front();
            n_checks++;
            if (g !== e) begin n_fail++; $display("FAIL stall_word%0d: got %h expected %h", n, g, e); end
            n++;
        end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_start_ignored;
        int lat, dones, n;
        for (int i = 0; i < DIM; i++) begin
            op_a[i] = {$urandom, $urandom} & 64'h0303_0303_0303_0303;
            op_b[i] = {$urandom, $urandom} & 64'h0303_0303_0303_0303;
        end
        run_job(1'b0, 1'b0, -1, 0, 1'b1, lat, dones);
        n_checks++;
        if (dones !== 1 || lat !== job_lat(1'b0)) begin
            n_fail++; $display("FAIL start_ignored: got %0d dones lat %0d expected 1 lat %0d", dones, lat, job_lat(1'b0));
        end
        n = 0;
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            logic [63:0] g, e;
            g = got_q.pop_front(); e = exp_q.pop_front();
            n_checks++;
            if (g !== e) begin n_fail++; $display("FAIL start_word%0d: got %h expected %h", n, g, e); end
            n++;
        end
        n_checks++;
        if (n !== 2*DIM) begin n_fail++; $display("FAIL start_count: got %0d words expected %0d", n, 2*DIM); end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_reset_mid_job;
        int lat, dones, sent, k, w0, m0, n;
        bit found;
        for (int i = 0; i < DIM; i++) begin
            op_a[i] = {$urandom, $urandom} & 64'h0F0F_0F0F_0F0F_0F0F;
            op_b[i] = {$urandom, $urandom} & 64'h0F0F_0F0F_0F0F_0F0F;
        end
        start = 1'b1; accum = 1'b0;
        @(posedge clk); @(negedge clk);
        start = 1'b0;
        sent = 0; found = 1'b0; k = 0;
        while (!found && k < 200) begin
            op_valid = 1'b0;
            if (op_ready && sent < 2*DIM) begin
                op_valid = 1'b1;
                op_data  = (sent < DIM) ? op_a[sent] : op_b[sent - DIM];
                sent++;
            end
            if (busy && !op_ready && !res_valid && !done && tpu_addr == '0) found = 1'b1;
            else begin @(posedge clk); k++; @(negedge clk); end
        end
        op_valid = 1'b0;
        n_checks++;
        if (!found) begin n_fail++; $display("FAIL rstmid_reach: got no MM_WAIT within %0d cycles expected one", k); end
        w0 = wr_total; m0 = mm_count;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({busy, done, op_ready, res_valid, tpu_r_w} !== 5'b0 || tpu_addr !== '0 || tpu_din !== '0) begin
            n_fail++;
            $display("FAIL rstmid_outputs: got ctrl=%b addr=%h din=%h expected zero",
                     {busy, done, op_ready, res_valid, tpu_r_w}, tpu_addr, tpu_din);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (wr_total !== w0 || mm_count !== m0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_abandon: got %0d writes %0d kicks busy=%b expected 0 0 0", wr_total - w0, mm_count - m0, busy);
        end
        run_job(1'b0, 1'b0, -1, 0, 1'b0, lat, dones);
        n_checks++;
        if (lat !== job_lat(1'b0) || dones !== 1) begin
            n_fail++; $display("FAIL rstmid_rerun: got lat %0d dones %0d expected %0d 1", lat, dones, job_lat(1'b0));
        end
        n = 0;
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            logic [63:0] g, e;
            g = got_q.pop_front(); e = exp_q.pop_front();
            n_checks++;
            if (g !== e) begin n_fail++; $display("FAIL rstmid_word%0d: got %h expected %h", n, g, e); end
            n++;
        end
        n_checks++;
        if (n !== 2*DIM || bad_wr !== 0) begin
            n_fail++; $display("FAIL rstmid_count: got %0d words %0d stray writes expected %0d 0", n, bad_wr, 2*DIM);
        end
        exp_q.delete(); got_q.delete();
    endtask

    initial begin
        test_reset();
        test_identity();
        test_accum();
        test_valid_gaps();
        test_res_stall();
        test_start_ignored();
        test_reset_mid_job();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
